// File: rtl/sub2_pkg.sv
// Shared types for the 2-bit adder recovery pipeline: operand widths,
// per-stage payloads and the subtraction that inverts the adder.
package sub2_pkg;

    localparam int SUM_W  = 3;
    localparam int OPND_W = 2;
    localparam int DIFF_W = 4;

    typedef struct packed {
        logic [SUM_W-1:0]  s;
        logic [OPND_W-1:0] b;
    } s1_pay_t;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic              err;
    } s2_pay_t;

    // diff is 4-bit two's complement: bit 3 means s < b, bit 2 alone means s - b > 3.
    function automatic s2_pay_t recover(input s1_pay_t p);
        logic [DIFF_W-1:0] diff;
        s2_pay_t           r;
        diff  = {1'b0, p.s} - {2'b00, p.b};
        r.a   = diff[OPND_W-1:0];
        r.err = diff[3] | diff[2];
        return r;
    endfunction

endpackage

// File: rtl/sub2_recover_pipe_if.sv
// Upstream (s/b) and downstream (a/err) valid/ready handshakes of the recovery pipe.
interface sub2_recover_pipe_if;
    import sub2_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [SUM_W-1:0]  s;
    logic [OPND_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [OPND_W-1:0] a;
    logic              err;

    modport master (
        output in_valid, s, b, out_ready,
        input  in_ready, out_valid, a, err
    );

    modport slave (
        input  in_valid, s, b, out_ready,
        output in_ready, out_valid, a, err
    );

endinterface

// File: rtl/sub2_pipe_stage.sv
// Generic valid/ready register slice; ready depends only on its own valid
// and the downstream ready, never on in_valid.
module sub2_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sub2_recover_pipe.sv
// Two-stage recovery of addend a from sum s and addend b, with a saturating
// count of consumed out-of-range results.
module sub2_recover_pipe
    import sub2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    sub2_recover_pipe_if.slave  bus,
    output logic [CNT_W-1:0]    err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    s1_pay_t s1_in;
    s1_pay_t s1_q;
    s2_pay_t s2_d;
    s2_pay_t s2_q;
    logic    s1_valid;
    logic    s2_ready;
    logic    consume;

    assign s1_in = {bus.s, bus.b};

    sub2_pipe_stage #(.W($bits(s1_pay_t))) u_s1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    // Subtraction sits between the slices so a/err come straight from S2 flops.
    assign s2_d = recover(s1_q);

    sub2_pipe_stage #(.W($bits(s2_pay_t))) u_s2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_d),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_q)
    );

    assign bus.a   = s2_q.a;
    assign bus.err = s2_q.err;
    assign consume = bus.out_valid && bus.out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (consume && bus.err && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sub2_recover_pipe.sv
// Bench for sub2_recover_pipe: directed vector table, backpressure, throughput,
// reset and saturation sequences, plus random traffic against a queue model.
module tb_sub2_recover_pipe;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [CNT_W-1:0] err_count;

    sub2_recover_pipe_if bus();

    sub2_recover_pipe #(.CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    // Model: in-flight items in order, tagged with the edge that accepted them.
    typedef struct { int s; int b; int edge_no; } item_t;
    typedef struct { logic [2:0] s; logic [1:0] b; logic [1:0] a; logic err; } vec_t;

    item_t q[$];
    int    seen_a[$];
    int    m_cnt;
    int    edge_no;
    int    checks;
    int    failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive, compare against model, then advance model on the edge.
    task automatic cycle(input logic iv, input logic [2:0] si, input logic [1:0] bi,
                         input logic ordy, output logic acc);
        logic vis;
        logic exp_rdy;
        logic cons;
        int   d;
        bus.in_valid  = iv;
        bus.s         = si;
        bus.b         = bi;
        bus.out_ready = ordy;
        #1;
        d       = 0;
        vis     = (q.size() > 0) && (q[0].edge_no < edge_no);
        exp_rdy = (q.size() < 2) || ordy;
        check("out_valid", bus.out_valid, vis);
        check("in_ready", bus.in_ready, exp_rdy);
        check("err_count", err_count, m_cnt);
        if (vis) begin
            d = q[0].s - q[0].b;
            check("a", bus.a, d & 3);
            check("err", bus.err, (d < 0 || d > 3));
        end
        acc  = iv && exp_rdy;
        cons = vis && ordy;
        if (cons) seen_a.push_back(int'(bus.a));
        @(posedge clock);
        edge_no++;
        if (cons) begin
            if ((d < 0 || d > 3) && m_cnt < CNT_MAX) m_cnt++;
            void'(q.pop_front());
        end
        if (acc) q.push_back('{int'(si), int'(bi), edge_no});
        @(negedge clock);
    endtask

    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst out_valid", bus.out_valid, 0);
        check("rst err_count", err_count, 0);
        check("rst in_ready", bus.in_ready, 1);
        check("rst a", bus.a, 0);
        check("rst err", bus.err, 0);
        q.delete();
        m_cnt = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t       vt[8];
        logic       acc;
        logic       pv;
        logic [2:0] ps;
        logic [1:0] pb;
        int         k;
        int         run;
        int         maxrun;
        int         nvalid;

        checks   = 0;
        failures = 0;
        m_cnt    = 0;
        edge_no  = 0;
        pv       = 1'b0;
        ps       = '0;
        pb       = '0;

        vt[0] = '{3'd5, 2'd2, 2'd3, 1'b0};
        vt[1] = '{3'd1, 2'd3, 2'd2, 1'b1};
        vt[2] = '{3'd6, 2'd1, 2'd1, 1'b1};
        vt[3] = '{3'd0, 2'd0, 2'd0, 1'b0};
        vt[4] = '{3'd7, 2'd3, 2'd0, 1'b1};
        vt[5] = '{3'd3, 2'd3, 2'd0, 1'b0};
        vt[6] = '{3'd0, 2'd1, 2'd3, 1'b1};
        vt[7] = '{3'd4, 2'd0, 2'd0, 1'b1};

        bus.in_valid  = 1'b0;
        bus.s         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b1;
        #1 reset_n    = 1'b0;
        repeat (2) @(negedge clock);
        check("reset in_ready", bus.in_ready, 1);
        check("reset out_valid", bus.out_valid, 0);
        check("reset a", bus.a, 0);
        check("reset err", bus.err, 0);
        check("reset err_count", err_count, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed table: one isolated transfer per vector.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vt[i].s, vt[i].b, 1'b1, acc);
            cycle(1'b0, 3'd0, 2'd0, 1'b1, acc);
            check($sformatf("tbl%0d out_valid", i), bus.out_valid, 1);
            check($sformatf("tbl%0d a", i), bus.a, vt[i].a);
            check($sformatf("tbl%0d err", i), bus.err, vt[i].err);
            cycle(1'b0, 3'd0, 2'd0, 1'b1, acc);
            if (i == 2) check("err_count after 2 errs", err_count, 2);
        end
        check("tbl err_count saturated", err_count, 3);

        // Backpressure: 4 items with the sink stalled, then release.
        seen_a.delete();
        k = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(k < 4, 3'(k), 2'd0, 1'b0, acc);
            if (acc) k++;
        end
        check("bp in_ready low", bus.in_ready, 0);
        check("bp out_valid", bus.out_valid, 1);
        check("bp a hold", bus.a, 0);
        for (int c = 0; c < 10; c++) begin
            cycle(k < 4, 3'(k), 2'd0, 1'b1, acc);
            if (acc) k++;
        end
        check("bp results", seen_a.size(), 4);
        for (int i = 0; i < 4 && i < seen_a.size(); i++)
            check($sformatf("bp order%0d", i), seen_a[i], i);

        // Full throughput: 16 back-to-back items, s = b + k.
        run    = 0;
        maxrun = 0;
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(i < 16, 3'(i / 4 + i % 4), 2'(i / 4), 1'b1, acc);
            if (bus.out_valid) begin
                nvalid++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        check("thr valid cycles", nvalid, 16);
        check("thr run length", maxrun, 16);

        // Mid-stream reset with both stages full.
        cycle(1'b1, 3'd1, 2'd3, 1'b0, acc);
        cycle(1'b1, 3'd6, 2'd1, 1'b0, acc);
        check("pre-rst in_ready", bus.in_ready, 0);
        async_reset();
        cycle(1'b1, 3'd5, 2'd2, 1'b1, acc);
        cycle(1'b0, 3'd0, 2'd0, 1'b1, acc);
        check("post-rst out_valid", bus.out_valid, 1);
        check("post-rst a", bus.a, 3);
        cycle(1'b0, 3'd0, 2'd0, 1'b1, acc);

        // Saturation: 5 erroring results consumed.
        for (int i = 0; i < 8; i++) begin
            cycle(i < 5, 3'd0, 2'(1 + i % 3), 1'b1, acc);
            if (i == 2) check("sat step1", err_count, 1);
            if (i == 3) check("sat step2", err_count, 2);
        end
        check("sat hold", err_count, 3);

        // Random traffic; upstream holds an item until it is accepted.
        for (int c = 0; c < 300; c++) begin
            if (!pv && $urandom_range(0, 3) != 0) begin
                pv = 1'b1;
                ps = 3'($urandom);
                pb = 2'($urandom);
            end
            cycle(pv, ps, pb, $urandom_range(0, 2) != 0, acc);
            if (acc) pv = 1'b0;
        end
        for (int c = 0; c < 4; c++) cycle(1'b0, 3'd0, 2'd0, 1'b1, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub2_recover_pipe.md
# sub2_recover_pipe

Two-stage pipelined recovery unit that inverts the 2-bit adder: given a registered 3-bit sum and one 2-bit addend, it recovers the other addend and flags sums no 2-bit addend can produce. It sits downstream of the adder blocks as a checker/decoder stage. Valid/ready handshakes on both sides give full throughput with backpressure. A saturating counter tracks consumed error results.

## Interface
Parameters:
- CNT_W, 8, width of the saturating error counter.

Ports:
- clock  in  1  single clock; all state updates on posedge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds s/b valid.
- in_ready  out  1  block can accept this cycle.
- s  in  3  sum operand, {s2,s1,s0}.
- b  in  2  known addend, {b1,b0}.
- out_valid  out  1  a/err hold a result.
- out_ready  in  1  downstream accepts this cycle.
- a  out  2  recovered addend, s − b modulo 4.
- err  out  1  1 when s − b < 0 or s − b > 3.
- err_count  out  CNT_W  number of consumed results with err=1, saturating.

## Operation
- Accept: in_valid && in_ready. Stage 1 (S1) captures s and b and sets s1_valid.
- S1→S2 advance when s1_valid && (!s2_valid || out_ready).
- S2 computes diff = {1'b0,s} − {2'b00,b} as a 4-bit two's-complement value, registered.
  - a = diff[1:0].
  - err = diff[3] | diff[2]. diff[3]=1 is negative; diff[2]=1 with diff[3]=0 is >3.
- out_valid = s2_valid. a and err are S2 register outputs, with no combinational path from inputs.
- in_ready = !s1_valid || !s2_valid || out_ready. There is no combinational path from in_valid.
- Consume: out_valid && out_ready clears s2_valid unless S1 advances in the same cycle.
- err_count increments by 1 on a consume with err=1. It holds at 2^CNT_W − 1.
- Holding rules:
  - While out_valid && !out_ready, a and err hold stable.
  - While in_ready is 0, S1 holds its contents.
- Reset (asynchronous, any time including mid-transfer): s1_valid=0, s2_valid=0, a=0, err=0, err_count=0. In-flight data is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, a=2'b00, err=0, err_count=0.
- Latency: accept at edge N gives out_valid=1 after edge N+1, i.e. valid throughout cycle N+1 and consumable at edge N+2.
- Throughput: 1 result per cycle with out_ready held high.
- Backpressure: with out_ready=0, at most 2 items are buffered.
  - in_ready drops the cycle after both stages are full.
  - It rises combinationally when out_ready=1.
- Simultaneous accept, advance and consume in one cycle is legal. No bubble is inserted and no item is lost.
- err_count updates on the same edge as the consume. It is visible the following cycle.
- Reset deassertion needs no synchronizer inside the block; the system provides it.

## Structure
- Shared package sub2_pkg:
  - SUM_W=3, OPND_W=2, DIFF_W=4.
  - A typedef for the S1 payload struct {s, b}.
  - A typedef for the S2 payload struct {a, err}.
- One sub-module, sub2_pipe_stage: a generic valid/ready register slice parameterized on payload width. It is instantiated twice; the subtraction sits between the two instances.
- err_count lives in the top level.

## Test plan
- Reset then single transfer: s=5, b=2 with out_ready=1 → out_valid two cycles after accept, a=3, err=0, err_count=0.
- Out-of-range cases:
  - s=1, b=3 → a=2 (diff −2, i.e. 4'b1110), err=1.
  - s=6, b=1 → a=1, err=1.
  - After consuming both, err_count=2.
- Backpressure: stream 4 items (s=0..3, b=0) with out_ready=0.
  - in_ready=0 after 2 accepts; outputs hold a=0.
  - Release out_ready → results a=0,1,2,3 in order, none dropped or duplicated.
- Full throughput: 16 back-to-back inputs covering all b, s=b+k for k=0..3 → 16 consecutive out_valid cycles, each a=k, err=0.
- Saturation: CNT_W=2, 5 erroring results consumed → err_count climbs 1,2,3 and stays 3.
- Mid-stream reset: assert reset_n=0 asynchronously with both stages full → out_valid=0 and err_count=0 immediately.
  - in_ready=1 after release.
  - The next accepted item emerges with correct a after 2-cycle latency.
